// File: rtl/shift_sched_pkg.sv
// Shared types for the two-requester PISO scheduler.
// State codes, owner indices and the grant one-hot helper.
package shift_sched_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic OWN_REQ0 = 1'b0;
  localparam logic OWN_REQ1 = 1'b1;

  function automatic logic [1:0] own2oh(input logic idx);
    return (idx == OWN_REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shift_sched_piso.sv
// Parallel-in/serial-out register; load beats shift.
// Shifts toward the output end selected by msb_first, filling zeros.
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             msb_first,
  input  logic [WIDTH-1:0] data_in,
  output logic             bit_out
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= data_in;
    end else if (en) begin
      if (msb_first)
        r_q <= {r_q[WIDTH-2:0], 1'b0};
      else
        r_q <= {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign bit_out = msb_first ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler feeding one shared PISO register.
// Reload on the last-bit cycle gives zero-gap back-to-back frames.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic             req_msb0,
  input  logic             req_msb1,
  output logic [1:0]       req_ready,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             ser_owner,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_msb;
  logic             r_owner;
  logic             r_rr;

  logic             w_shift;
  logic             w_cnt0;
  logic             w_win;
  logic             w_hs;
  logic             w_adv;
  logic             w_gidx;
  logic [WIDTH-1:0] w_data;
  logic             w_msb_in;
  logic             w_bit;

  assign w_shift = (r_state == S_SHIFT);
  assign w_cnt0  = (r_cnt == '0);
  assign w_adv   = w_shift & ser_ready;

  // Accept window: idle, or the cycle the last bit is consumed.
  assign w_win = ~rst & (~w_shift | (w_cnt0 & ser_ready));
  assign w_hs  = w_win & (|req_valid);

  always_comb begin
    w_gidx = r_rr;
    unique case (req_valid)
      2'b01:   w_gidx = OWN_REQ0;
      2'b10:   w_gidx = OWN_REQ1;
      default: w_gidx = r_rr;
    endcase
  end

  assign req_ready = w_hs ? own2oh(w_gidx) : 2'b00;
  assign w_data    = (w_gidx == OWN_REQ1) ? req_data1 : req_data0;
  assign w_msb_in  = (w_gidx == OWN_REQ1) ? req_msb1 : req_msb0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_msb   <= 1'b0;
      r_owner <= OWN_REQ0;
      r_rr    <= OWN_REQ0;
    end else if (w_hs) begin
      r_state <= S_SHIFT;
      r_cnt   <= CNT_W'(WIDTH - 1);
      r_msb   <= w_msb_in;
      r_owner <= w_gidx;
      r_rr    <= ~w_gidx;
    end else if (w_adv) begin
      if (w_cnt0)
        r_state <= S_IDLE;
      else
        r_cnt <= r_cnt - 1'b1;
    end
  end

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (w_hs),
    .en       (w_adv),
    .msb_first(r_msb),
    .data_in  (w_data),
    .bit_out  (w_bit)
  );

  assign ser_valid = w_shift;
  assign ser_out   = w_shift & w_bit;
  assign ser_last  = w_shift & w_cnt0 & ~rst;
  assign ser_owner = r_owner;
  assign busy      = w_shift;

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: bit-queue reference model plus
// directed frames with literal timing and content checks.
module tb_shift_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [W-1:0] req_data0 = '0;
  logic [W-1:0] req_data1 = '0;
  logic         req_msb0 = 1'b0;
  logic         req_msb1 = 1'b0;
  logic [1:0]   req_ready;
  logic         ser_ready = 1'b1;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         ser_owner;
  logic         busy;

  shift_sched #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data0(req_data0),
    .req_data1(req_data1),
    .req_msb0 (req_msb0),
    .req_msb1 (req_msb1),
    .req_ready(req_ready),
    .ser_ready(ser_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_last (ser_last),
    .ser_owner(ser_owner),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // requester word queues: {msb, data}
  logic [W:0] wq0[$];
  logic [W:0] wq1[$];
  bit hs0 = 0;
  bit hs1 = 0;

  // model state: bits still to be emitted for the current frame(s)
  bit   mq[$];
  bit   m_own = 0;
  bit   m_rr  = 0;

  // logs for literal checks
  logic [31:0] cap_word;
  logic [31:0] cap_own;
  int          cap_n;
  int          last_cyc[$];
  int          gnt_cyc[$];
  bit          gnt_q[$];

  bit         e_valid, e_out, e_last, win, g_any, g;
  logic [1:0] e_ready;
  logic [W-1:0] d;
  logic       dm;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_last", 32'(ser_last), 32'd0);
      mq.delete();
      m_rr = 0;
      hs0 = 0;
      hs1 = 0;
    end else begin
      e_valid = (mq.size() != 0);
      e_out   = e_valid ? mq[0] : 1'b0;
      e_last  = (mq.size() == 1);
      chk("valid", 32'(ser_valid), 32'(e_valid));
      chk("busy", 32'(busy), 32'(e_valid));
      chk("last", 32'(ser_last), 32'(e_last));
      chk("out", 32'(ser_out), 32'(e_out));
      if (e_valid) chk("owner", 32'(ser_owner), 32'(m_own));
      win   = (mq.size() == 0) || (mq.size() == 1 && ser_ready);
      g_any = win && (req_valid != 2'b00);
      g     = (req_valid == 2'b01) ? 1'b0 :
              (req_valid == 2'b10) ? 1'b1 : m_rr;
      e_ready = g_any ? (g ? 2'b10 : 2'b01) : 2'b00;
      chk("ready", 32'(req_ready), 32'(e_ready));
      if (ser_valid && ser_ready) begin
        cap_word = {cap_word[30:0], ser_out};
        cap_own  = {cap_own[30:0], ser_owner};
        cap_n++;
        if (ser_last) last_cyc.push_back(cyc);
      end
      hs0 = req_valid[0] & req_ready[0];
      hs1 = req_valid[1] & req_ready[1];
      if (hs0 | hs1) begin
        gnt_q.push_back(hs1);
        gnt_cyc.push_back(cyc);
      end
      if (e_valid && ser_ready) void'(mq.pop_front());
      if (g_any) begin
        d  = g ? req_data1 : req_data0;
        dm = g ? req_msb1 : req_msb0;
        for (int i = 0; i < W; i++)
          mq.push_back(dm ? d[W-1-i] : d[i]);
        m_own = g;
        m_rr  = !g;
      end
    end
  end

  // requesters hold valid+data until accepted
  always @(posedge clk) begin
    #2;
    if (hs0) begin void'(wq0.pop_front()); hs0 = 0; end
    if (hs1) begin void'(wq1.pop_front()); hs1 = 0; end
    req_valid[0] = (wq0.size() != 0);
    req_valid[1] = (wq1.size() != 0);
    if (wq0.size() != 0) {req_msb0, req_data0} = wq0[0];
    if (wq1.size() != 0) {req_msb1, req_data1} = wq1[0];
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    cap_word = '0;
    cap_own  = '0;
    cap_n    = 0;
    last_cyc.delete();
    gnt_cyc.delete();
    gnt_q.delete();
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    cycles(1);
    while ((wq0.size() != 0 || wq1.size() != 0 || busy ||
            req_valid != 2'b00) && k < budget) begin
      @(posedge clk);
      #3;
      k++;
    end
    n_vec++;
    if (k >= budget) begin
      n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles", nm, k);
    end
    cycles(2);
  endtask

  task automatic wait_bits(input string nm, input int n);
    int k = 0;
    while (cap_n < n && k < 100) begin
      cycles(1);
      k++;
    end
    n_vec++;
    if (k >= 100) begin
      n_bad++;
      $display("FAIL %s_wait: %0d bits seen, wanted %0d", nm, cap_n, n);
    end
  endtask

  int nlast_rel;
  int nbits_rel;

  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(ser_valid), 32'd0);

    // 1: single msb-first word from requester 0
    clr_logs();
    wq0.push_back({1'b1, 8'hAC});
    drain("t1", 60);
    chk("t1_bits", cap_word[7:0], 32'hAC);
    chk("t1_nbits", cap_n, 8);
    chk("t1_owner", cap_own[7:0], 32'h00);
    chk("t1_nlast", last_cyc.size(), 1);
    chk("t1_lat", last_cyc[0] - gnt_cyc[0], 8);

    // 2: both valid from reset, back-to-back frames
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    clr_logs();
    wq0.push_back({1'b1, 8'hAC});
    wq1.push_back({1'b1, 8'hF0});
    drain("t2", 80);
    chk("t2_ngnt", gnt_q.size(), 2);
    chk("t2_g0", 32'(gnt_q[0]), 0);
    chk("t2_g1", 32'(gnt_q[1]), 1);
    chk("t2_reload", gnt_cyc[1], last_cyc[0]);
    chk("t2_bits", cap_word[15:0], 32'hACF0);
    chk("t2_owner", cap_own[15:0], 32'h00FF);
    chk("t2_nogap", last_cyc[1] - gnt_cyc[0], 16);

    // 3: lsb-first word from requester 1
    clr_logs();
    wq1.push_back({1'b0, 8'hF0});
    drain("t3", 60);
    chk("t3_bits", cap_word[7:0], 32'h0F);
    chk("t3_owner", cap_own[7:0], 32'hFF);

    // 4: backpressure for 3 cycles after the 3rd bit
    clr_logs();
    wq0.push_back({1'b1, 8'hAC});
    wait_bits("t4", 3);
    ser_ready = 1'b0;
    cycles(3);
    ser_ready = 1'b1;
    drain("t4", 60);
    chk("t4_bits", cap_word[7:0], 32'hAC);
    chk("t4_nbits", cap_n, 8);
    chk("t4_lat", last_cyc[0] - gnt_cyc[0], 11);

    // 5: continuous contention alternates
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    clr_logs();
    wq0.push_back({1'b1, 8'h5A});
    wq0.push_back({1'b1, 8'h3C});
    wq1.push_back({1'b1, 8'h81});
    wq1.push_back({1'b1, 8'hE7});
    drain("t5", 120);
    chk("t5_ngnt", gnt_q.size(), 4);
    chk("t5_order", {28'd0, gnt_q[0], gnt_q[1], gnt_q[2], gnt_q[3]},
        32'b0101);
    chk("t5_bits", cap_word, 32'h5A813CE7);
    chk("t5_span", last_cyc[3] - gnt_cyc[0], 32);

    // 6: reset during the 5th bit aborts the frame
    clr_logs();
    wq0.push_back({1'b1, 8'hC3});
    wq1.push_back({1'b1, 8'h96});
    wait_bits("t6", 4);
    rst = 1'b1;
    wq0.push_back({1'b1, 8'h55});
    cycles(1);
    rst = 1'b0;
    nlast_rel = last_cyc.size();
    nbits_rel = cap_n;
    chk("t6_nolast", nlast_rel, 0);
    chk("t6_partial", nbits_rel, 4);
    chk("t6_busy", 32'(busy), 32'd0);
    drain("t6", 80);
    chk("t6_ngnt", gnt_q.size(), 3);
    chk("t6_rr0", 32'(gnt_q[1]), 0);
    chk("t6_rr1", 32'(gnt_q[2]), 1);
    chk("t6_bits", cap_word[19:0], 32'hC5596);
    chk("t6_nlast", last_cyc.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
